// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI frame transmitter and its matching receiver.
package spi_frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      LOW,
      HIGH,
      DONE
   } state_t;

   localparam int DEFAULT_CDEPTH      = 4;
   localparam int DEFAULT_FRAME_ORDER = 10;

   function automatic int pix_width(input int cdepth);
      return 3 * cdepth;
   endfunction

endpackage

// File: rtl/sck_phase_timer.sv
// Times one sck half period of 2**SCK_DIV_BITS clk cycles; shared by the low and high phases.
module sck_phase_timer #(
   parameter int SCK_DIV_BITS = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic phase_end
);

   logic [SCK_DIV_BITS-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (run) begin
         count <= count + 1'b1;
      end
   end

   assign phase_end = run && (count == '1);

endmodule

// File: rtl/spi_frame_tx.sv
// SPI master streaming one frame of pixels LSB first from a registered pixel RAM.
// Optional test-pattern generator is enabled with SPI_FRAME_TX_PATTERN_EN.
module spi_frame_tx
   import spi_frame_pkg::*;
#(
   parameter int CDEPTH       = DEFAULT_CDEPTH,
   parameter int FRAME_ORDER  = DEFAULT_FRAME_ORDER,
   parameter int SCK_DIV_BITS = 3,
   localparam int PW          = pix_width(CDEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
`ifdef SPI_FRAME_TX_PATTERN_EN
   input  logic                   pattern,
`endif
   output logic [FRAME_ORDER-1:0] raddr,
   input  logic [PW-1:0]          rpix,
   output logic                   sck,
   output logic                   sdi,
   output logic                   busy,
   output logic                   done
);

   localparam int BW = $clog2(PW);
   localparam logic [BW-1:0] LAST_BIT = BW'(PW - 1);

   state_t                 state;
   state_t                 next_state;
   logic [PW-1:0]          shreg;
   logic [BW-1:0]          bit_cnt;
   logic [FRAME_ORDER-1:0] pix_addr;
   logic [PW-1:0]          load_pix;
   logic                   phase_end;
   logic                   phase_run;
   logic                   phase_clear;

`ifdef SPI_FRAME_TX_PATTERN_EN
   logic                          pattern_q;
   logic [CDEPTH+FRAME_ORDER-1:0] addr_ext;

   // Zero-extend so the channel slice stays legal even for tiny frames.
   assign addr_ext = {{CDEPTH{1'b0}}, pix_addr};
   assign load_pix = pattern_q ? {3{addr_ext[CDEPTH-1:0]}} : rpix;

   always_ff @(posedge clk) begin
      if (reset) begin
         pattern_q <= 1'b0;
      end else if (state == IDLE && start) begin
         pattern_q <= pattern;
      end
   end
`else
   assign load_pix = rpix;
`endif

   sck_phase_timer #(
      .SCK_DIV_BITS(SCK_DIV_BITS)
   ) u_phase_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (phase_clear),
      .run      (phase_run),
      .phase_end(phase_end)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Any state change restarts the phase timer, so LOW and HIGH each begin at count 0.
   always_comb begin
      next_state  = state;
      phase_run   = 1'b0;
      sck         = 1'b0;
      sdi         = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) next_state = FETCH;
         end
         FETCH: next_state = LOAD;
         LOAD:  next_state = LOW;
         LOW: begin
            phase_run = 1'b1;
            sdi       = shreg[0];
            if (phase_end) next_state = HIGH;
         end
         HIGH: begin
            phase_run = 1'b1;
            sck       = 1'b1;
            sdi       = shreg[0];
            if (phase_end) begin
               if (bit_cnt < LAST_BIT)    next_state = LOW;
               else if (pix_addr == '1)   next_state = DONE;
               else                       next_state = FETCH;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      phase_clear = (next_state != state);
   end

   // Shift happens only at the end of HIGH, so sdi is frozen for the whole high phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         pix_addr <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         case (state)
            IDLE: begin
               pix_addr <= '0;
               bit_cnt  <= '0;
            end
            LOAD: shreg <= load_pix;
            HIGH: begin
               if (phase_end) begin
                  shreg <= shreg >> 1;
                  if (next_state == FETCH) begin
                     pix_addr <= pix_addr + 1'b1;
                     bit_cnt  <= '0;
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign raddr = pix_addr;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: random frames, start misuse, mid-frame reset, SPI receiver model.
`timescale 1ns/1ps
module tb_spi_frame_tx;

   localparam int CDEPTH       = 4;
   localparam int FRAME_ORDER  = 3;
   localparam int SCK_DIV_BITS = 2;
   localparam int PW           = 3 * CDEPTH;
   localparam int NPIX         = 1 << FRAME_ORDER;
   localparam int H            = 1 << SCK_DIV_BITS;
   localparam int PIX_CYCLES   = PW * 2 * H + 2;
   localparam int FRAME_EDGES  = NPIX * PIX_CYCLES;
   localparam int FIRST_RISE   = 2 + H;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   start = 1'b0;
`ifdef SPI_FRAME_TX_PATTERN_EN
   logic                   pattern = 1'b0;
`endif
   logic [FRAME_ORDER-1:0] raddr;
   logic [PW-1:0]          rpix;
   logic                   sck;
   logic                   sdi;
   logic                   busy;
   logic                   done;

   logic [PW-1:0] mem [NPIX];
   logic [PW-1:0] exp_word_q[$];
   int            exp_start_q[$];

   int checks     = 0;
   int errors     = 0;
   int edge_cnt   = 0;
   int dones      = 0;
   int exp_dones  = 0;
   int setup_viol = 0;
   int last_start = 0;

   spi_frame_tx #(
      .CDEPTH      (CDEPTH),
      .FRAME_ORDER (FRAME_ORDER),
      .SCK_DIV_BITS(SCK_DIV_BITS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
`ifdef SPI_FRAME_TX_PATTERN_EN
      .pattern(pattern),
`endif
      .raddr (raddr),
      .rpix  (rpix),
      .sck   (sck),
      .sdi   (sdi),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Registered pixel RAM: data appears one clk after the address.
   always @(posedge clk) rpix <= mem[raddr];

   task automatic check_output(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Receiver model: gathers sdi at each sck rise into LSB-first words and checks timing.
   logic          prev_sck  = 1'b0;
   logic          prev_sdi  = 1'b0;
   logic          prev_busy = 1'b0;
   logic          prev_done = 1'b0;
   logic [PW-1:0] rx_word   = '0;
   int            rx_bits   = 0;
   int            rises     = 0;
   int            hi_len    = 0;
   int            frame_start = 0;
   bit            first_pending = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         rx_bits       = 0;
         rises         = 0;
         hi_len        = 0;
         first_pending = 1'b0;
      end else begin
         if (busy && !prev_busy) begin
            check_output("start_expected", (exp_start_q.size() > 0), 1);
            if (exp_start_q.size() > 0) begin
               frame_start = exp_start_q.pop_front();
               check_output("busy_rise_edge", edge_cnt, frame_start);
            end
            rises         = 0;
            rx_bits       = 0;
            first_pending = 1'b1;
         end
         if (prev_done) check_output("busy_after_done", busy, 0);
         if (sck && !prev_sck) begin
            if (first_pending) begin
               check_output("first_rise_delay", edge_cnt - frame_start, FIRST_RISE);
               first_pending = 1'b0;
            end
            rx_word[rx_bits] = sdi;
            rx_bits++;
            rises++;
            hi_len = 0;
            if (rx_bits == PW) begin
               check_output("pixel_expected", (exp_word_q.size() > 0), 1);
               if (exp_word_q.size() > 0) check_output("pixel_word", rx_word, exp_word_q.pop_front());
               rx_bits = 0;
            end
         end
         if (sck) begin
            hi_len++;
            if (prev_sck && (sdi != prev_sdi)) setup_viol++;
         end
         if (!sck && prev_sck) check_output("sck_high_len", hi_len, H);
         if (done) begin
            check_output("done_edge", edge_cnt - frame_start, FRAME_EDGES);
            check_output("sck_rises_per_frame", rises, NPIX * PW);
            check_output("words_left_at_done", exp_word_q.size(), 0);
            dones++;
         end
      end
      prev_sck  = sck;
      prev_sdi  = sdi;
      prev_busy = busy;
      prev_done = done && !reset;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < NPIX; i++) mem[i] = PW'($urandom);
   endtask

   task automatic push_frame(input bit use_pattern);
      logic [PW-1:0] w;
      exp_start_q.push_back(edge_cnt);
      last_start = edge_cnt;
      for (int i = 0; i < NPIX; i++) begin
         w = use_pattern ? {3{CDEPTH'(i)}} : mem[i];
         exp_word_q.push_back(w);
      end
      exp_dones++;
   endtask

   task automatic apply_stimulus(input bit use_pattern);
`ifdef SPI_FRAME_TX_PATTERN_EN
      pattern = use_pattern;
`endif
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      push_frame(use_pattern);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (dones < exp_dones && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_output("done_within_budget", (dones >= exp_dones), 1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_output({tag, "_sck"},   sck,   0);
      check_output({tag, "_sdi"},   sdi,   0);
      check_output({tag, "_busy"},  busy,  0);
      check_output({tag, "_done"},  done,  0);
      check_output({tag, "_raddr"}, raddr, 0);
   endtask

   initial begin
      for (int i = 0; i < NPIX; i++) mem[i] = '0;
      reset = 1'b1;
      idle(3);
      check_idle_outputs("reset");
      reset = 1'b0;
      idle(2);

      // Constant 12'hA5C frame: every word must arrive LSB first.
      for (int i = 0; i < NPIX; i++) mem[i] = 12'hA5C;
      apply_stimulus(1'b0);
      wait_done(FRAME_EDGES + 100);
      idle(5);

      // Start pulsed three times while busy must not queue another frame.
      fill_random();
      apply_stimulus(1'b0);
      for (int k = 0; k < 3; k++) begin
         idle($urandom_range(50, 200));
         start = 1'b1;
         idle(1);
         start = 1'b0;
      end
      wait_done(FRAME_EDGES + 100);
      idle(FRAME_EDGES / 4);
      check_output("no_queued_frame", busy, 0);

      // Start held through done: next frame is taken on the following IDLE sample.
      fill_random();
      start = 1'b1;
      @(posedge clk);
      #1;
      push_frame(1'b0);
      wait_done(FRAME_EDGES + 100);
      @(posedge clk);
      #1;
      start = 1'b0;
      push_frame(1'b0);
      wait_done(FRAME_EDGES + 100);
      idle(5);

      // Reset in the middle of pixel 3, bit 5 aborts without a done pulse.
      fill_random();
      apply_stimulus(1'b0);
      while (edge_cnt < last_start + 3 * PIX_CYCLES + 2 + 5 * 2 * H + 1) idle(1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_idle_outputs("abort");
      exp_word_q.delete();
      exp_start_q.delete();
      exp_dones--;
      idle(20);
      check_output("no_done_after_abort", dones, exp_dones);

      fill_random();
      apply_stimulus(1'b0);
      wait_done(FRAME_EDGES + 100);

      repeat (3) begin
         fill_random();
         idle($urandom_range(1, 20));
         apply_stimulus(1'b0);
         wait_done(FRAME_EDGES + 100);
      end

`ifdef SPI_FRAME_TX_PATTERN_EN
      fill_random();
      idle(3);
      apply_stimulus(1'b1);
      wait_done(FRAME_EDGES + 100);
      pattern = 1'b0;
`endif

      idle(10);
      check_output("done_count", dones, exp_dones);
      check_output("sdi_change_while_sck_high", setup_viol, 0);
      check_output("leftover_words", exp_word_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] simulation timeout");
   end

endmodule
